// File: rtl/map_pkg.sv
// Shared types and the default tile map for the tile map controller.
package map_pkg;

  typedef enum logic [1:0] {
    TileRoad  = 2'd0,
    TileBrick = 2'd1,
    TileSteel = 2'd2,
    TileWater = 2'd3
  } tile_t;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StQResp,
    StWCommit
  } state_e;

  localparam int unsigned MAP_W    = 16;
  localparam int unsigned MAP_H    = 16;
  localparam int unsigned MapCells = MAP_W * MAP_H;

  // Border is steel, even/even interior cells form a brick pillar grid, the rest is road.
  function automatic logic [2*MapCells-1:0] build_default_map();
    logic [2*MapCells-1:0] m;
    m = '0;
    for (int unsigned y = 0; y < MAP_H; y++) begin
      for (int unsigned x = 0; x < MAP_W; x++) begin
        if (x == 0 || y == 0 || x == MAP_W - 1 || y == MAP_H - 1) begin
          m[2*(y*MAP_W+x) +: 2] = 2'(TileSteel);
        end else if ((x % 2 == 0) && (y % 2 == 0)) begin
          m[2*(y*MAP_W+x) +: 2] = 2'(TileBrick);
        end else begin
          m[2*(y*MAP_W+x) +: 2] = 2'(TileRoad);
        end
      end
    end
    return m;
  endfunction

  localparam logic [2*MapCells-1:0] DEFAULT_MAP = build_default_map();

  function automatic tile_t default_tile(logic [7:0] idx);
    return tile_t'(DEFAULT_MAP[2*int'(idx) +: 2]);
  endfunction

endpackage

// File: rtl/map_controller_if.sv
// Renderer, query, write and reload signals between requesters and the map controller.
interface map_controller_if;
  import map_pkg::*;

  logic [3:0] rd_x;
  logic [3:0] rd_y;
  tile_t      rd_tile;

  logic       q_req;
  logic [3:0] q_x;
  logic [3:0] q_y;
  logic       q_ack;
  tile_t      q_tile;

  logic       w_req;
  logic [3:0] w_x;
  logic [3:0] w_y;
  tile_t      w_tile;
  logic       w_ack;
  logic       w_ok;

  logic       load;
  logic       busy;

  modport master (
    output rd_x, rd_y, q_req, q_x, q_y, w_req, w_x, w_y, w_tile, load,
    input  rd_tile, q_ack, q_tile, w_ack, w_ok, busy
  );

  modport slave (
    input  rd_x, rd_y, q_req, q_x, q_y, w_req, w_x, w_y, w_tile, load,
    output rd_tile, q_ack, q_tile, w_ack, w_ok, busy
  );

endinterface

// File: rtl/map_ram.sv
// Synchronous dual-port tile store: port A read-only, port B read/write, read-before-write.
module map_ram import map_pkg::*; #(
  parameter int unsigned Depth = 256,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic [Aw-1:0] a_addr_i,
  output tile_t         a_rdata_o,
  input  logic [Aw-1:0] b_addr_i,
  input  logic          b_we_i,
  input  tile_t         b_wdata_i,
  output tile_t         b_rdata_o
);

  tile_t mem_q [Depth];
  tile_t a_rdata_q;
  tile_t b_rdata_q;

  always_ff @(posedge clk_i) begin
    a_rdata_q <= mem_q[a_addr_i];
    b_rdata_q <= mem_q[b_addr_i];
    if (b_we_i) begin
      mem_q[b_addr_i] <= b_wdata_i;
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/map_controller.sv
// Tile map controller: reload sweep, arbitrated collision queries and steel-protected writes.
module map_controller #(
  parameter int unsigned MAP_W       = map_pkg::MAP_W,
  parameter int unsigned MAP_H       = map_pkg::MAP_H,
  parameter int unsigned INIT_CYCLES = MAP_W * MAP_H
) (
  input logic             clk,
  input logic             rst,
  map_controller_if.slave bus
);
  import map_pkg::*;

  localparam int unsigned Depth   = MAP_W * MAP_H;
  localparam logic [7:0]  LastIdx = 8'(INIT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_w_q, last_w_d;  // 1: write won the most recent contended grant
  logic       load_pend_q, load_pend_d;
  logic [7:0] addr_q, addr_d;
  tile_t      wtile_q, wtile_d;

  logic [7:0] ram_addr;
  logic       ram_we;
  tile_t      ram_wdata;
  tile_t      ram_rdata;
  tile_t      rd_rdata;
  logic       old_steel;

  assign old_steel = (ram_rdata == TileSteel);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      last_w_q    <= 1'b1;
      load_pend_q <= 1'b0;
      addr_q      <= '0;
      wtile_q     <= TileRoad;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_w_q    <= last_w_d;
      load_pend_q <= load_pend_d;
      addr_q      <= addr_d;
      wtile_q     <= wtile_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_w_d    = last_w_q;
    load_pend_d = load_pend_q;
    addr_d      = addr_q;
    wtile_d     = wtile_q;
    ram_addr    = addr_q;
    ram_we      = 1'b0;
    ram_wdata   = wtile_q;

    unique case (state_q)
      StInit: begin
        ram_addr    = cnt_q;
        ram_we      = 1'b1;
        ram_wdata   = default_tile(cnt_q);
        load_pend_d = 1'b0;
        cnt_d       = cnt_q + 8'd1;
        if (cnt_q == LastIdx) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (bus.load || load_pend_q) begin
          state_d     = StInit;
          cnt_d       = '0;
          load_pend_d = 1'b0;
        end else if (bus.q_req && (!bus.w_req || last_w_q)) begin
          addr_d   = {bus.q_y, bus.q_x};
          ram_addr = {bus.q_y, bus.q_x};
          state_d  = StQResp;
          if (bus.w_req) begin
            last_w_d = 1'b0;
          end
        end else if (bus.w_req) begin
          addr_d   = {bus.w_y, bus.w_x};
          ram_addr = {bus.w_y, bus.w_x};
          wtile_d  = bus.w_tile;
          state_d  = StWCommit;
          if (bus.q_req) begin
            last_w_d = 1'b1;
          end
        end
      end
      StQResp: begin
        if (bus.load) begin
          load_pend_d = 1'b1;
        end
        state_d = StIdle;
      end
      StWCommit: begin
        if (bus.load) begin
          load_pend_d = 1'b1;
        end
        ram_we  = !old_steel;
        state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  assign bus.busy    = (state_q == StInit);
  assign bus.q_ack   = (state_q == StQResp);
  assign bus.q_tile  = (state_q == StQResp) ? ram_rdata : TileRoad;
  assign bus.w_ack   = (state_q == StWCommit);
  assign bus.w_ok    = (state_q == StWCommit) && !old_steel;
  assign bus.rd_tile = bus.busy ? TileRoad : rd_rdata;

  map_ram #(
    .Depth(Depth)
  ) u_map_ram (
    .clk_i    (clk),
    .a_addr_i ({bus.rd_y, bus.rd_x}),
    .a_rdata_o(rd_rdata),
    .b_addr_i (ram_addr),
    .b_we_i   (ram_we),
    .b_wdata_i(ram_wdata),
    .b_rdata_o(ram_rdata)
  );

endmodule

// File: tb/tb_map_controller.sv
// Scoreboard bench for map_controller: directed requests push expected acks, a monitor checks them.
module tb_map_controller;
  import map_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  map_controller_if bus ();

  map_controller dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic  is_w;
    tile_t tile;
    logic  ok;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_check(input logic is_w, input tile_t tile, input logic ok);
    exp_t e;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_ack: is_w=%0d with empty scoreboard", is_w);
    end else begin
      e = sb_q.pop_front();
      chk("ack_kind", 32'(is_w), 32'(e.is_w));
      if (!is_w) chk("q_tile", 32'(tile), 32'(e.tile));
      else       chk("w_ok", 32'(ok), 32'(e.ok));
    end
  endtask

  // Monitor: consumes every ack the DUT presents.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy && (bus.q_ack || bus.w_ack)) begin
        failures++;
        $display("FAIL ack_while_busy: q_ack=%0d w_ack=%0d", bus.q_ack, bus.w_ack);
      end
      if (bus.q_ack) pop_check(1'b0, bus.q_tile, 1'b0);
      if (bus.w_ack) pop_check(1'b1, TileRoad, bus.w_ok);
    end
  end

  task automatic wait_ack(input bit is_q, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(is_q ? bus.q_ack : bus.w_ack) && lat < 20);
  endtask

  task automatic do_query(input logic [3:0] x, input logic [3:0] y, input tile_t exp);
    int lat;
    @(negedge clk);
    bus.q_x = x; bus.q_y = y; bus.q_req = 1'b1;
    sb_q.push_back('{is_w: 1'b0, tile: exp, ok: 1'b0});
    wait_ack(1'b1, lat);
    bus.q_req = 1'b0;
    chk("q_latency", 32'(lat), 32'd1);
  endtask

  task automatic do_write(input logic [3:0] x, input logic [3:0] y, input tile_t t,
                          input logic exp_ok);
    int lat;
    @(negedge clk);
    bus.w_x = x; bus.w_y = y; bus.w_tile = t; bus.w_req = 1'b1;
    sb_q.push_back('{is_w: 1'b1, tile: TileRoad, ok: exp_ok});
    wait_ack(1'b0, lat);
    bus.w_req = 1'b0;
    chk("w_latency", 32'(lat), 32'd1);
  endtask

  // Both requests raised together; expected order is pushed by the caller's choice.
  task automatic contend(input bit query_first, input logic [3:0] qx, input logic [3:0] qy,
                         input tile_t qexp, input logic [3:0] wx, input logic [3:0] wy,
                         input tile_t wt, input logic wok);
    bit q_done = 0;
    bit w_done = 0;
    int n = 0;
    exp_t qe = '{is_w: 1'b0, tile: qexp, ok: 1'b0};
    exp_t we = '{is_w: 1'b1, tile: TileRoad, ok: wok};
    @(negedge clk);
    bus.q_x = qx; bus.q_y = qy; bus.q_req = 1'b1;
    bus.w_x = wx; bus.w_y = wy; bus.w_tile = wt; bus.w_req = 1'b1;
    if (query_first) begin sb_q.push_back(qe); sb_q.push_back(we); end
    else             begin sb_q.push_back(we); sb_q.push_back(qe); end
    while (!(q_done && w_done) && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.q_ack) begin bus.q_req = 1'b0; q_done = 1; end
      if (bus.w_ack) begin bus.w_req = 1'b0; w_done = 1; end
    end
    chk("contend_done", 32'(q_done && w_done), 32'd1);
    bus.q_req = 1'b0;
    bus.w_req = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [3:0] x, input logic [3:0] y,
                          input tile_t exp);
    @(negedge clk);
    bus.rd_x = x; bus.rd_y = y;
    @(negedge clk);
    chk(name, 32'(bus.rd_tile), 32'(exp));
  endtask

  task automatic count_busy(input string name, input bit probe_rd);
    int n = 0;
    while (bus.busy && n < 400) begin
      if (probe_rd && n == 10) chk("rd_road_while_busy", 32'(bus.rd_tile), 32'(TileRoad));
      n++;
      @(negedge clk);
    end
    chk(name, 32'(n), 32'd256);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.rd_x = 4'd2; bus.rd_y = 4'd2;
    bus.q_req = 1'b0; bus.q_x = '0; bus.q_y = '0;
    bus.w_req = 1'b0; bus.w_x = '0; bus.w_y = '0; bus.w_tile = TileRoad;
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_q_ack", 32'(bus.q_ack), 32'd0);
    chk("rst_w_ack", 32'(bus.w_ack), 32'd0);
    chk("rst_w_ok", 32'(bus.w_ok), 32'd0);
    chk("rst_q_tile", 32'(bus.q_tile), 32'(TileRoad));
    chk("rst_rd_tile", 32'(bus.rd_tile), 32'(TileRoad));
    rst = 1'b0;
    count_busy("init_busy_cycles", 1'b1);

    rd_check("rd_0_0", 4'd0, 4'd0, TileSteel);
    rd_check("rd_1_1", 4'd1, 4'd1, TileRoad);
    rd_check("rd_2_2", 4'd2, 4'd2, TileBrick);
    rd_check("rd_15_7", 4'd15, 4'd7, TileSteel);

    do_query(4'd2, 4'd2, TileBrick);
    do_query(4'd3, 4'd5, TileRoad);
    do_write(4'd2, 4'd2, TileRoad, 1'b1);
    rd_check("rd_2_2_destroyed", 4'd2, 4'd2, TileRoad);
    do_write(4'd0, 4'd0, TileRoad, 1'b0);
    rd_check("rd_0_0_steel_kept", 4'd0, 4'd0, TileSteel);
    do_write(4'd3, 4'd3, TileWater, 1'b1);
    do_query(4'd3, 4'd3, TileWater);

    // First contention goes to the query, the next one to the write.
    contend(1'b1, 4'd0, 4'd0, TileSteel, 4'd4, 4'd4, TileWater, 1'b1);
    contend(1'b0, 4'd6, 4'd6, TileWater, 4'd6, 4'd6, TileWater, 1'b1);
    rd_check("rd_6_6_water", 4'd6, 4'd6, TileWater);

    // Load during the write commit: write completes, then a full reload.
    @(negedge clk);
    bus.w_x = 4'd2; bus.w_y = 4'd2; bus.w_tile = TileRoad; bus.w_req = 1'b1;
    sb_q.push_back('{is_w: 1'b1, tile: TileRoad, ok: 1'b1});
    wait_ack(1'b0, n);
    chk("load_w_latency", 32'(n), 32'd1);
    bus.w_req = 1'b0;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("idle_before_reload", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("reload_started", 32'(bus.busy), 32'd1);
    count_busy("reload_busy_cycles", 1'b0);
    rd_check("rd_2_2_restored", 4'd2, 4'd2, TileBrick);
    rd_check("rd_6_6_restored", 4'd6, 4'd6, TileBrick);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/map_controller.md
MAP_CONTROLLER -- requirements
Module: map_controller

Interface
REQ-001 Parameters SHALL be: MAP_W default 16, number of tile columns; MAP_H default 16, number of tile rows; INIT_CYCLES default MAP_W*MAP_H, length of the map reload sweep.
REQ-002 clk  in  1  single clock; every register SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 rd_x, rd_y  in  4 each  renderer tile coordinate.
REQ-005 rd_tile  out  2  renderer tile type (tile_t).
REQ-006 q_req  in  1  collision query request; q_x, q_y  in  4 each  query coordinate.
REQ-007 q_ack  out  1  query done pulse; q_tile  out  2  queried tile type.
REQ-008 w_req  in  1  tile write request; w_x, w_y  in  4 each  write coordinate; w_tile  in  2  new tile type.
REQ-009 w_ack  out  1  write done pulse; w_ok  out  1  write committed (0 = target was steel).
REQ-010 load  in  1  reload the default map.
REQ-011 busy  out  1  reload in progress.

Function
REQ-012 Tile types SHALL be ROAD=0, BRICK=1, STEEL=2, WATER=3; the map SHALL be addressed [y][x].
REQ-013 Renderer port: rd_tile SHALL equal map[rd_y][rd_x] sampled one cycle earlier, every cycle, independent of arbitration; a write to the same address in the same cycle SHALL return the old value.
REQ-014 While busy=1, rd_tile SHALL be ROAD.
REQ-015 FSM states SHALL be INIT, IDLE, Q_RESP, W_COMMIT.
REQ-016 INIT SHALL write DEFAULT_MAP entries 0..INIT_CYCLES-1 in that order, one per cycle, using an 8-bit counter; busy SHALL be 1 throughout; the state SHALL go to IDLE after the last entry.
REQ-017 IDLE with load pending SHALL go to INIT; load SHALL take priority over q_req and w_req.
REQ-018 IDLE with q_req only SHALL read map[q_y][q_x] and go to Q_RESP; IDLE with w_req only SHALL read map[w_y][w_x] and go to W_COMMIT.
REQ-019 When q_req and w_req are both high in IDLE, the grant SHALL go to the requester not granted last; last_grant SHALL reset to "write", so the first contention goes to the query.
REQ-020 Q_RESP SHALL assert q_ack=1 for one cycle with q_tile valid, then go to IDLE.
REQ-021 W_COMMIT SHALL write w_tile when the old tile is not STEEL, set w_ok=1 in that case and w_ok=0 otherwise, assert w_ack=1 for one cycle, then go to IDLE.
REQ-022 Latency SHALL be one cycle from grant to ack; throughput SHALL be one serviced request per 2 cycles.
REQ-023 Requesters SHALL hold coordinates and data stable while req=1 and drop req in the cycle after ack; the controller SHALL sample coordinates only at grant.
REQ-024 A load asserted in INIT SHALL be ignored; a load asserted in Q_RESP or W_COMMIT SHALL be latched, the current transaction SHALL complete, and INIT SHALL start on the next IDLE cycle.
REQ-025 No ack SHALL be issued while busy=1.

Reset
REQ-026 On rst: state=INIT, counter=0, last_grant=write, load latch cleared, q_ack=0, w_ack=0, w_ok=0, q_tile=ROAD, rd_tile=ROAD, busy=1.
REQ-027 rst asserted mid-transaction SHALL abort it with no ack, and a full reload SHALL follow.

Structure
REQ-028 Package map_pkg SHALL hold tile_t, MAP_W, MAP_H and DEFAULT_MAP (border STEEL, interior walls BRICK, rest ROAD).
REQ-029 Storage SHALL be a sub-module map_ram, synchronous dual-port (one read-only port for the renderer, one read/write port for the controller), 256x2 bits.

Verification
REQ-030 Reset: after rst is released, busy SHALL stay 1 for 256 cycles then fall; rd (0,0) SHALL give STEEL, rd (1,1) ROAD, rd (2,2) BRICK.
REQ-031 Query: q_req at (2,2) -> q_ack the next cycle with q_tile=BRICK.
REQ-032 Destroy: w_req (2,2) ROAD -> w_ack with w_ok=1; rd (2,2) afterwards SHALL give ROAD.
REQ-033 Steel protection: w_req (0,0) ROAD -> w_ack with w_ok=0; rd (0,0) SHALL still give STEEL.
REQ-034 Contention: q_req and w_req raised in the same cycle twice in succession -> order SHALL be query, write, then write, query.
REQ-035 load raised during W_COMMIT of a write to (2,2) ROAD -> w_ack occurs, then 256 busy cycles, then rd (2,2) SHALL give BRICK.
